// File: rtl/ycbcr_to_rgb_stream_if.sv
// Pixel stream interface for ycbcr_to_rgb_stream.
// Carries the YCbCr input handshake and the RGB output handshake.
// slave  : converter view (consumes YCbCr, produces RGB)
// master : upstream/downstream environment view
interface ycbcr_to_rgb_stream_if #(
  parameter int PIX_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] y_in;
  logic [PIX_W-1:0] cb_in;
  logic [PIX_W-1:0] cr_in;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] r_out;
  logic [PIX_W-1:0] g_out;
  logic [PIX_W-1:0] b_out;
  logic             out_last;

  modport slave (
    input  in_valid, y_in, cb_in, cr_in, out_ready,
    output in_ready, out_valid, r_out, g_out, b_out, out_last
  );

  modport master (
    output in_valid, y_in, cb_in, cr_in, out_ready,
    input  in_ready, out_valid, r_out, g_out, b_out, out_last
  );
endinterface

// File: rtl/ycbcr_to_rgb_stream.sv
// ycbcr_to_rgb_stream: streaming YCbCr -> RGB converter, 3-stage pipeline.
// Stage 1 registers Y<<10 and the four Q10 chroma products, stage 2 forms
// the rounded sums, stage 3 floors, clamps to 0..2^PIX_W-1 and drives the
// outputs. All stages shift together when advance = !out_valid | out_ready.
// A 6-bit input pixel counter tags pixel BLK_PIX-1 of each 8x8 block.
// Optional feature macro: YCBCR_SAT_COUNT_EN adds sat_count[6:0], the number
// of clamped output pixels in the most recently completed block.
module ycbcr_to_rgb_stream #(
  parameter int PIX_W   = 10,
  parameter int BLK_PIX = 64
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  ycbcr_to_rgb_stream_if.slave  bus
`ifdef YCBCR_SAT_COUNT_EN
  ,
  output logic [6:0]            sat_count
`endif
);

  localparam int CNT_W  = 6;
  localparam int PROD_W = 22;
  localparam int SUM_W  = 24;

  localparam logic signed [PROD_W-1:0] KR  = 22'sd1436;
  localparam logic signed [PROD_W-1:0] KGB = 22'sd352;
  localparam logic signed [PROD_W-1:0] KGR = 22'sd731;
  localparam logic signed [PROD_W-1:0] KB  = 22'sd1815;
  localparam logic signed [SUM_W-1:0]  ROUND_HALF = 24'sd512;
  localparam logic signed [SUM_W-1:0]  PIX_MAX    = SUM_W'((1 << PIX_W) - 1);
  localparam logic [CNT_W-1:0]         LAST_IDX   = CNT_W'(BLK_PIX - 1);

  // Sign-extend a two's complement chroma sample to product width.
  function automatic logic signed [PROD_W-1:0] sx_chroma(input logic [PIX_W-1:0] c);
    return {{(PROD_W-PIX_W){c[PIX_W-1]}}, c};
  endfunction

  // Sign-extend a product to sum width.
  function automatic logic signed [SUM_W-1:0] sx_prod(input logic signed [PROD_W-1:0] p);
    return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Floor the Q10 sum and saturate it into the unsigned pixel range.
  function automatic logic [PIX_W-1:0] clamp_q10(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] q;
    q = s >>> 10;
    if (q[SUM_W-1]) begin
      return '0;
    end else if (q > PIX_MAX) begin
      return PIX_MAX[PIX_W-1:0];
    end else begin
      return q[PIX_W-1:0];
    end
  endfunction

`ifdef YCBCR_SAT_COUNT_EN
  // True when the floored Q10 sum lies outside the pixel range.
  function automatic logic clips_q10(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] q;
    q = s >>> 10;
    return q[SUM_W-1] | (q > PIX_MAX);
  endfunction
`endif

  logic                     advance;
  logic                     xfer;
  logic [CNT_W-1:0]         pix_cnt;

  logic                     v1, v2, v3;
  logic                     tag1, tag2, tag3;
  logic signed [SUM_W-1:0]  y1;
  logic signed [PROD_W-1:0] p_kr, p_kgb, p_kgr, p_kb;
  logic signed [SUM_W-1:0]  s_r, s_g, s_b;
  logic [PIX_W-1:0]         r_q, g_q, b_q;

  logic signed [SUM_W-1:0]  y_x;
  logic signed [PROD_W-1:0] cb_x, cr_x;
  logic signed [SUM_W-1:0]  sum_r, sum_g, sum_b;

  assign advance = ~v3 | bus.out_ready;
  assign xfer    = bus.in_valid & advance;

  assign y_x  = {{(SUM_W-PIX_W-10){1'b0}}, bus.y_in, 10'd0};
  assign cb_x = sx_chroma(bus.cb_in);
  assign cr_x = sx_chroma(bus.cr_in);

  assign sum_r = y1 + sx_prod(p_kr) + ROUND_HALF;
  assign sum_g = y1 - sx_prod(p_kgb) - sx_prod(p_kgr) + ROUND_HALF;
  assign sum_b = y1 + sx_prod(p_kb) + ROUND_HALF;

  assign bus.in_ready  = advance;
  assign bus.out_valid = v3;
  assign bus.r_out     = r_q;
  assign bus.g_out     = g_q;
  assign bus.b_out     = b_q;
  assign bus.out_last  = tag3;

  // Pixel index within the block, advanced on each accepted input pixel.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt <= '0;
    end else if (xfer) begin
      pix_cnt <= (pix_cnt == LAST_IDX) ? '0 : pix_cnt + 6'd1;
    end else begin
      pix_cnt <= pix_cnt;
    end
  end

  // Stage 1: scaled luma, chroma products and last-pixel tag.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      v1    <= 1'b0;
      tag1  <= 1'b0;
      y1    <= '0;
      p_kr  <= '0;
      p_kgb <= '0;
      p_kgr <= '0;
      p_kb  <= '0;
    end else if (advance) begin
      v1    <= bus.in_valid;
      tag1  <= (pix_cnt == LAST_IDX);
      y1    <= y_x;
      p_kr  <= KR * cr_x;
      p_kgb <= KGB * cb_x;
      p_kgr <= KGR * cr_x;
      p_kb  <= KB * cb_x;
    end
  end

  // Stage 2: rounded Q10 sums per colour.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      v2   <= 1'b0;
      tag2 <= 1'b0;
      s_r  <= '0;
      s_g  <= '0;
      s_b  <= '0;
    end else if (advance) begin
      v2   <= v1;
      tag2 <= tag1;
      s_r  <= sum_r;
      s_g  <= sum_g;
      s_b  <= sum_b;
    end
  end

  // Stage 3: floor, clamp and present the output pixel.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      v3   <= 1'b0;
      tag3 <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else if (advance) begin
      v3   <= v2;
      tag3 <= tag2;
      r_q  <= clamp_q10(s_r);
      g_q  <= clamp_q10(s_g);
      b_q  <= clamp_q10(s_b);
    end
  end

`ifdef YCBCR_SAT_COUNT_EN
  logic       sat3;
  logic [6:0] sat_acc;

  // Stage 3 companion: remember whether the presented pixel was clamped.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sat3 <= 1'b0;
    end else if (advance) begin
      sat3 <= clips_q10(s_r) | clips_q10(s_g) | clips_q10(s_b);
    end
  end

  // Count clamped pixels per block; publish the total on the block's last transfer.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sat_acc   <= '0;
      sat_count <= '0;
    end else if (v3 && bus.out_ready) begin
      if (tag3) begin
        sat_count <= sat_acc + {6'd0, sat3};
        sat_acc   <= '0;
      end else begin
        sat_acc   <= sat_acc + {6'd0, sat3};
      end
    end
  end
`endif

endmodule

// File: tb/tb_ycbcr_to_rgb_stream.sv
// Scoreboard bench for ycbcr_to_rgb_stream: accepted input pixels are run
// through an integer reference model and queued; a negedge monitor pops and
// compares every output transfer and checks stall stability.
module tb_ycbcr_to_rgb_stream;
  localparam int PIX_W   = 10;
  localparam int BLK_PIX = 64;

  logic clk_in  = 1'b0;
  logic reset_n = 1'b0;

  ycbcr_to_rgb_stream_if #(.PIX_W(PIX_W)) bus ();
`ifdef YCBCR_SAT_COUNT_EN
  logic [6:0] sat_count;
`endif

  ycbcr_to_rgb_stream #(.PIX_W(PIX_W), .BLK_PIX(BLK_PIX)) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef YCBCR_SAT_COUNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int r;
    int g;
    int b;
    bit last;
    bit sat;
  } pix_t;

  pix_t exp_q[$];
  int   last_pos[$];
  int   checks    = 0;
  int   errors    = 0;
  int   model_idx = 0;
  int   out_ord   = 0;
  bit   rand_ready = 1'b0;
  bit   fixed_ready = 1'b0;

  // Reference model: real-valued conversion realised as Q10 integer math with floor.
  function automatic int floor_div1024(int n);
    if (n >= 0) return n / 1024;
    else return -((-n + 1023) / 1024);
  endfunction

  function automatic int clip(int v);
    if (v < 0) return 0;
    else if (v > 1023) return 1023;
    else return v;
  endfunction

  function automatic pix_t model(int y, int cb, int cr, bit last);
    pix_t p;
    int sr, sg, sb;
    sr = floor_div1024(y * 1024 + 1436 * cr + 512);
    sg = floor_div1024(y * 1024 - 352 * cb - 731 * cr + 512);
    sb = floor_div1024(y * 1024 + 1815 * cb + 512);
    p.r = clip(sr);
    p.g = clip(sg);
    p.b = clip(sb);
    p.sat = (p.r != sr) || (p.g != sg) || (p.b != sb);
    p.last = last;
    return p;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready driver: random or fixed out_ready, changed 2 time units after each rising edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk_in);
      #2;
      bus.out_ready = rand_ready ? ($urandom_range(0, 9) < 7) : fixed_ready;
    end
  end

  // Monitor: sample at negedge, push accepted inputs, pop and compare output transfers.
  bit   stalled = 1'b0;
  pix_t held;
`ifdef YCBCR_SAT_COUNT_EN
  int sat_acc_m = 0;
  bit sat_pend  = 1'b0;
  int sat_exp   = 0;
`endif
  always @(negedge clk_in) begin
    if (!reset_n) begin
      stalled = 1'b0;
      out_ord = 0;
`ifdef YCBCR_SAT_COUNT_EN
      sat_acc_m = 0;
      sat_pend  = 1'b0;
`endif
    end else begin
`ifdef YCBCR_SAT_COUNT_EN
      if (sat_pend) begin
        check("sat_count", int'(sat_count), sat_exp);
        sat_pend = 1'b0;
      end
`endif
      if (stalled) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_r", int'(bus.r_out), held.r);
        check("stall_g", int'(bus.g_out), held.g);
        check("stall_b", int'(bus.b_out), held.b);
        check("stall_last", int'(bus.out_last), int'(held.last));
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(int'(bus.y_in), int'($signed(bus.cb_in)),
                              int'($signed(bus.cr_in)), model_idx == BLK_PIX - 1));
        model_idx = (model_idx + 1) % BLK_PIX;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pixel r=%0d g=%0d b=%0d, expected no output",
                   bus.r_out, bus.g_out, bus.b_out);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          check("pix_r", int'(bus.r_out), e.r);
          check("pix_g", int'(bus.g_out), e.g);
          check("pix_b", int'(bus.b_out), e.b);
          check("pix_last", int'(bus.out_last), int'(e.last));
          if (e.last) last_pos.push_back(out_ord);
`ifdef YCBCR_SAT_COUNT_EN
          sat_acc_m += int'(e.sat);
          if (e.last) begin
            sat_exp   = sat_acc_m;
            sat_pend  = 1'b1;
            sat_acc_m = 0;
          end
`endif
        end
        out_ord++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held.r = int'(bus.r_out);
      held.g = int'(bus.g_out);
      held.b = int'(bus.b_out);
      held.last = bus.out_last;
    end
  end

  // Present one pixel and hold it until accepted (bounded).
  task automatic send(int y, int cb, int cr);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.y_in  = y[9:0];
    bus.cb_in = cb[9:0];
    bus.cr_in = cr[9:0];
    while (!ok && n < 200) begin
      @(negedge clk_in);
      ok = bus.in_ready;
      @(posedge clk_in);
      #2;
      n++;
    end
    if (!ok) check("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    last_pos.delete();
    model_idx = 0;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk_in);
    #2;
    reset_n = 1'b1;
  endtask

  // Let the pipeline empty with out_ready high; an expired budget is a failure.
  task automatic drain();
    int n;
    fixed_ready = 1'b1;
    rand_ready  = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk_in);
      #2;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.y_in  = '0;
    bus.cb_in = '0;
    bus.cr_in = '0;
    repeat (3) @(posedge clk_in);
    #2;
    reset_n = 1'b1;
    #1;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_r", int'(bus.r_out), 0);
    check("reset_g", int'(bus.g_out), 0);
    check("reset_b", int'(bus.b_out), 0);
    check("reset_last", int'(bus.out_last), 0);
    @(posedge clk_in);
    #2;

    // Grey pass-through and latency of exactly three advancing cycles.
    fixed_ready = 1'b1;
    idle(1);
    send(500, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_in);
      check("latency_valid", int'(bus.out_valid), (k == 3) ? 1 : 0);
    end
    @(posedge clk_in);
    #2;

    // Clamp and mixed vectors, back to back.
    send(1023, 0, 511);
    send(0, -512, 0);
    send(512, 100, -100);
    drain();

    // Block framing: 130 continuous pixels from a fresh index 0.
    do_reset();
    fixed_ready = 1'b1;
    for (int i = 0; i < 130; i++) begin
      send($urandom_range(0, 1023), $urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512);
    end
    drain();
    check("frame_last_count", last_pos.size(), 2);
    check("frame_last0", (last_pos.size() > 0) ? last_pos[0] : -1, 63);
    check("frame_last1", (last_pos.size() > 1) ? last_pos[1] : -1, 127);

    // Random bubbles and back-pressure, with one reset in the middle of a block.
    rand_ready = 1'b1;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 2));
      if (i == 300) do_reset();
      send($urandom_range(0, 1023), $urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
